// File: rtl/step_counter_pkg.sv
// step_counter_pkg: FSM encoding and clamp/compare helpers
// shared by the stepped ramp counter and its next-value unit.
package step_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Helpers work on a word wide enough for WIDTH+1 <= SC_MAXW.
  localparam int SC_MAXW = 33;

  typedef logic [SC_MAXW-1:0] sc_word_t;

  function automatic sc_word_t sc_clamp(
    input sc_word_t v,
    input sc_word_t lo,
    input sc_word_t hi
  );
    sc_word_t r;
    r = v;
    if (v < lo) begin
      r = lo;
    end else if (v > hi) begin
      r = hi;
    end
    return r;
  endfunction

  function automatic sc_word_t sc_absdiff(
    input sc_word_t a,
    input sc_word_t b
  );
    sc_word_t r;
    if (a > b) begin
      r = a - b;
    end else begin
      r = b - a;
    end
    return r;
  endfunction

  function automatic logic sc_bad_bounds(
    input sc_word_t lo,
    input sc_word_t hi
  );
    return lo > hi;
  endfunction

endpackage

// File: rtl/step_clamp_unit.sv
// step_clamp_unit: combinational next-count for one step of +/-step,
// clamped to [lo,hi] or wrapped modulo (hi-lo+1). Ports: count, step, dir_up,
// lo/hi_bound, wrap_en -> next_count, clamped, wrapped_flag.
module step_clamp_unit #(
  parameter int WIDTH      = 16,
  parameter int STEP_WIDTH = 16
) (
  input  logic [WIDTH-1:0]      count,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic                  dir_up,
  input  logic [WIDTH-1:0]      lo_bound,
  input  logic [WIDTH-1:0]      hi_bound,
  input  logic                  wrap_en,
  output logic [WIDTH-1:0]      next_count,
  output logic                  clamped,
  output logic                  wrapped_flag
);

  localparam int XW = WIDTH + 1;

  logic [XW-1:0] w_cnt;
  logic [XW-1:0] w_step;
  logic [XW-1:0] w_lo;
  logic [XW-1:0] w_hi;
  logic [XW-1:0] w_rng;
  logic [XW-1:0] w_sum;
  logic [XW-1:0] w_dif;
  logic [XW-1:0] w_lo_st;
  logic          w_can_wrap;

  assign w_cnt   = {1'b0, count};
  assign w_step  = XW'(step);
  assign w_lo    = {1'b0, lo_bound};
  assign w_hi    = {1'b0, hi_bound};
  // range can be 2^WIDTH, hence the extra bit
  assign w_rng   = w_hi - w_lo + XW'(1);
  assign w_sum   = w_cnt + w_step;
  assign w_dif   = w_cnt - w_step;
  assign w_lo_st = w_lo + w_step;

  assign w_can_wrap = wrap_en && (w_step <= w_rng);

  always_comb begin
    next_count   = count;
    clamped      = 1'b0;
    wrapped_flag = 1'b0;
    if (step != '0) begin
      if (dir_up) begin
        if (w_sum > w_hi) begin
          if (w_can_wrap) begin
            next_count   = WIDTH'(w_sum - w_rng);
            wrapped_flag = 1'b1;
          end else begin
            next_count = hi_bound;
            clamped    = 1'b1;
          end
        end else if (w_sum < w_lo) begin
          next_count = lo_bound;
          clamped    = 1'b1;
        end else begin
          next_count = WIDTH'(w_sum);
        end
      end else begin
        // compare against lo+step so the subtraction never underflows
        if (w_cnt < w_lo_st) begin
          if (w_can_wrap) begin
            next_count   = WIDTH'(w_cnt + w_rng - w_step);
            wrapped_flag = 1'b1;
          end else begin
            next_count = lo_bound;
            clamped    = 1'b1;
          end
        end else if (w_dif > w_hi) begin
          next_count = hi_bound;
          clamped    = 1'b1;
        end else begin
          next_count = WIDTH'(w_dif);
        end
      end
    end
  end

endmodule

// File: rtl/stepped_ramp_counter.sv
// stepped_ramp_counter: bounded up/down step counter with load and a ramp FSM.
// Ports: clk, reset, en, upnotdown, stepwidth_in, lo/hi_bound, load, load_value,
// start, target, [wrap] -> out, busy, done, sat, [wrapped], at_min, at_max,
// bound_err. Define STEP_CNT_WRAP_EN to add the wrap input and wrapped pulse.
module stepped_ramp_counter
  import step_counter_pkg::*;
#(
  parameter int                WIDTH       = 16,
  parameter int                STEP_WIDTH  = 16,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  upnotdown,
  input  logic [STEP_WIDTH-1:0] stepwidth_in,
  input  logic [WIDTH-1:0]      lo_bound,
  input  logic [WIDTH-1:0]      hi_bound,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  start,
  input  logic [WIDTH-1:0]      target,
`ifdef STEP_CNT_WRAP_EN
  input  logic                  wrap,
`endif
  output logic [WIDTH-1:0]      out,
  output logic                  busy,
  output logic                  done,
  output logic                  sat,
`ifdef STEP_CNT_WRAP_EN
  output logic                  wrapped,
`endif
  output logic                  at_min,
  output logic                  at_max,
  output logic                  bound_err
);

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_tgt;
  logic             r_done;
  logic             r_sat;
  logic             r_wrapped;

  logic             w_berr;
  logic [WIDTH-1:0] w_ld_val;
  logic [WIDTH-1:0] w_st_tgt;
  logic [WIDTH-1:0] w_snap_val;
  logic             w_snap;
  logic             w_ramp_up;
  logic             w_in_ramp;
  logic             w_dir;
  logic             w_wrap_sel;
  logic [WIDTH-1:0] w_next;
  logic             w_clamped;
  logic             w_wrap_flag;
  logic             w_pinned;

  assign w_berr = sc_bad_bounds(sc_word_t'(lo_bound),
                                sc_word_t'(hi_bound));

  assign w_ld_val = WIDTH'(sc_clamp(sc_word_t'(load_value),
                                    sc_word_t'(lo_bound),
                                    sc_word_t'(hi_bound)));

  assign w_st_tgt = WIDTH'(sc_clamp(sc_word_t'(target),
                                    sc_word_t'(lo_bound),
                                    sc_word_t'(hi_bound)));

  // latched target is kept as-is; only the final snap honours new bounds
  assign w_snap_val = WIDTH'(sc_clamp(sc_word_t'(r_tgt),
                                      sc_word_t'(lo_bound),
                                      sc_word_t'(hi_bound)));

  assign w_snap = sc_absdiff(sc_word_t'(r_tgt), sc_word_t'(r_cnt))
                  <= sc_word_t'(stepwidth_in);

  assign w_ramp_up = r_tgt > r_cnt;
  assign w_in_ramp = (r_state == ST_RAMP);
  assign w_dir     = w_in_ramp ? w_ramp_up : upnotdown;

`ifdef STEP_CNT_WRAP_EN
  assign w_wrap_sel = wrap && !w_in_ramp;
`else
  assign w_wrap_sel = 1'b0;
`endif

  step_clamp_unit #(
    .WIDTH      (WIDTH),
    .STEP_WIDTH (STEP_WIDTH)
  ) u_clamp (
    .count        (r_cnt),
    .step         (stepwidth_in),
    .dir_up       (w_dir),
    .lo_bound     (lo_bound),
    .hi_bound     (hi_bound),
    .wrap_en      (w_wrap_sel),
    .next_count   (w_next),
    .clamped      (w_clamped),
    .wrapped_flag (w_wrap_flag)
  );

  // ramp cannot progress once pinned at the bound it is heading for
  assign w_pinned = w_clamped &&
                    (w_ramp_up ? (w_next == hi_bound)
                               : (w_next == lo_bound));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= RESET_VALUE;
      r_tgt     <= RESET_VALUE;
      r_state   <= ST_IDLE;
      r_done    <= 1'b0;
      r_sat     <= 1'b0;
      r_wrapped <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_sat     <= 1'b0;
      r_wrapped <= 1'b0;
      if (w_berr) begin
        if (r_state == ST_DONE) begin
          r_state <= ST_IDLE;
        end
      end else if (load) begin
        r_cnt   <= w_ld_val;
        r_state <= ST_IDLE;
      end else if (start) begin
        r_tgt <= w_st_tgt;
        if (w_st_tgt == r_cnt) begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end else begin
          r_state <= ST_RAMP;
        end
      end else begin
        unique case (r_state)
          ST_RAMP: begin
            if (stepwidth_in != '0) begin
              if (w_snap) begin
                r_cnt   <= w_snap_val;
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_cnt <= w_next;
                r_sat <= w_clamped;
                if (w_pinned) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                end
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            if (en) begin
              r_cnt     <= w_next;
              r_sat     <= w_clamped;
              r_wrapped <= w_wrap_flag;
            end
          end
        endcase
      end
    end
  end

  assign out       = r_cnt;
  assign busy      = w_in_ramp;
  assign done      = r_done;
  assign sat       = r_sat;
  assign at_min    = (r_cnt == lo_bound);
  assign at_max    = (r_cnt == hi_bound);
  assign bound_err = w_berr;

`ifdef STEP_CNT_WRAP_EN
  assign wrapped = r_wrapped;
`else
  logic w_unused_wrap;
  assign w_unused_wrap = r_wrapped | w_wrap_flag;
`endif

endmodule
